silib_usb_responder: RTL and testbench

//  FPGA-side responder for the SiLibUSB host bus. It converts RD_B/WR_B strobe cycles at external

---
 rtl/silib_usb_responder_pkg.sv | 23 ++
 rtl/silib_usb_responder_if.sv | 31 +++
 rtl/silib_usb_responder_fast_read.sv | 40 ++++
 rtl/silib_usb_responder.sv | 141 ++++++++++++++
 tb/tb_silib_usb_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/silib_usb_responder_pkg.sv
//------------------------------------------------------------------------------
// Module  : silib_usb_pkg
// Brief   : Shared types and defaults for the SiLibUSB host-bus responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package silib_usb_pkg;

  localparam logic [15:0] EXT_BASE_DEFAULT = 16'h4000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    WR_HOLD = 3'd2,
    RD_REQ  = 3'd3,
    RD_CAP  = 3'd4,
    RD_HOLD = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/silib_usb_responder_if.sv
//------------------------------------------------------------------------------
// Module  : silib_usb_responder_if
// Brief   : Internal basil bus and FWFT readout-FIFO signals of the responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface silib_usb_responder_if;

  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_OUT;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  FIFO_DATA;
  logic        FIFO_EMPTY;
  logic        FIFO_READ;

  modport master (
    output BUS_ADD, BUS_DATA_OUT, BUS_RD, BUS_WR, FIFO_READ,
    input  BUS_DATA_IN, FIFO_DATA, FIFO_EMPTY
  );

  modport slave (
    input  BUS_ADD, BUS_DATA_OUT, BUS_RD, BUS_WR, FIFO_READ,
    output BUS_DATA_IN, FIFO_DATA, FIFO_EMPTY
  );

endinterface

`default_nettype wire

// File: rtl/silib_usb_responder_fast_read.sv
//------------------------------------------------------------------------------
// Module  : silib_usb_fast_read
// Brief   : FastBlockRead path: FD byte mux, FIFO pop and underrun detect.
//           Underrun output exists only with SILIB_RESP_ERRCNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module silib_usb_fast_read #(
  parameter logic [7:0] EMPTY_FILL = 8'h00
) (
  input  logic       rst,
  input  logic       i_fread,
  input  logic       i_fstrobe,
  input  logic [7:0] i_fifo_data,
  input  logic       i_fifo_empty,
  output logic [7:0] o_fd,
  output logic       o_fd_oe,
  output logic       o_fifo_read
`ifdef SILIB_RESP_ERRCNT_EN
  ,
  output logic       o_underrun
`endif
);

  logic w_active;

  // Reset releases FD and suppresses pops without waiting for a clock edge.
  assign w_active    = i_fread & ~rst;
  assign o_fd        = i_fifo_empty ? EMPTY_FILL : i_fifo_data;
  assign o_fd_oe     = w_active;
  assign o_fifo_read = w_active & i_fstrobe & ~i_fifo_empty;

`ifdef SILIB_RESP_ERRCNT_EN
  assign o_underrun  = w_active & i_fstrobe & i_fifo_empty;
`endif

endmodule

`default_nettype wire

// File: rtl/silib_usb_responder.sv
//------------------------------------------------------------------------------
// Module  : silib_usb_responder
// Brief   : SiLibUSB host-strobe to basil-bus bridge plus FastBlockRead port.
//           Optional ERR_CNT output enabled by SILIB_RESP_ERRCNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module silib_usb_responder
  import silib_usb_pkg::*;
#(
  parameter logic [15:0] EXT_BASE   = EXT_BASE_DEFAULT,
  parameter logic [7:0]  EMPTY_FILL = 8'h00
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        RD_B,
  input  logic        WR_B,
  input  logic [15:0] ADD,
  inout  wire  [7:0]  DATA,
  input  logic        FREAD,
  input  logic        FSTROBE,
  inout  wire  [7:0]  FD,
  silib_usb_responder_if.master bus
`ifdef SILIB_RESP_ERRCNT_EN
  ,
  output logic [15:0] ERR_CNT
`endif
);

  state_t      r_state, w_state_nxt;
  logic        r_rd_b_q, r_wr_b_q;
  logic [15:0] r_addr, w_addr_nxt;
  logic [7:0]  r_wdata, w_wdata_nxt;
  logic [7:0]  r_rd_data;
  logic        w_rd_fall, w_wr_fall, w_in_range;
  logic [15:0] w_bus_addr;
  logic        w_data_oe;
  logic [7:0]  w_data_out;
  logic [7:0]  w_fd;
  logic        w_fd_oe;

  assign w_rd_fall  = ~RD_B & r_rd_b_q;
  assign w_wr_fall  = ~WR_B & r_wr_b_q;
  assign w_in_range = (ADD >= EXT_BASE);
  assign w_bus_addr = ADD - EXT_BASE;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_state   <= IDLE;
      r_rd_b_q  <= 1'b1;
      r_wr_b_q  <= 1'b1;
      r_addr    <= 16'h0000;
      r_wdata   <= 8'h00;
      r_rd_data <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_b_q <= RD_B;
      r_wr_b_q <= WR_B;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      if (r_state == RD_CAP) begin
        r_rd_data <= bus.BUS_DATA_IN;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      IDLE: begin
        // Simultaneous strobes are ambiguous about bus ownership; drop them.
        if (!(w_rd_fall && w_wr_fall) && w_in_range) begin
          if (w_wr_fall) begin
            w_state_nxt = WR_ACC;
            w_addr_nxt  = w_bus_addr;
            w_wdata_nxt = DATA;
          end else if (w_rd_fall) begin
            w_state_nxt = RD_REQ;
            w_addr_nxt  = w_bus_addr;
          end
        end
      end
      WR_ACC:  w_state_nxt = WR_HOLD;
      WR_HOLD: if (WR_B) w_state_nxt = IDLE;
      RD_REQ:  w_state_nxt = RD_CAP;
      RD_CAP:  w_state_nxt = RD_B ? IDLE : RD_HOLD;
      RD_HOLD: if (RD_B) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.BUS_WR       = (r_state == WR_ACC);
  assign bus.BUS_RD       = (r_state == RD_REQ);
  assign bus.BUS_ADD      = r_addr;
  assign bus.BUS_DATA_OUT = r_wdata;

  // Raw strobe levels gate the driver so DATA lets go in the cycle RD_B rises.
  assign w_data_oe  = ((r_state == RD_CAP) || (r_state == RD_HOLD)) && !RD_B && WR_B;
  assign w_data_out = (r_state == RD_CAP) ? bus.BUS_DATA_IN : r_rd_data;
  assign DATA       = w_data_oe ? w_data_out : 8'hzz;

`ifdef SILIB_RESP_ERRCNT_EN
  logic        w_underrun;
  logic [15:0] r_err_cnt;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_err_cnt <= 16'h0000;
    end else if ((w_underrun || (w_rd_fall && w_wr_fall)) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign ERR_CNT = r_err_cnt;
`endif

  silib_usb_fast_read #(
    .EMPTY_FILL (EMPTY_FILL)
  ) u_fast_read (
    .rst          (BUS_RST),
    .i_fread      (FREAD),
    .i_fstrobe    (FSTROBE),
    .i_fifo_data  (bus.FIFO_DATA),
    .i_fifo_empty (bus.FIFO_EMPTY),
    .o_fd         (w_fd),
    .o_fd_oe      (w_fd_oe),
    .o_fifo_read  (bus.FIFO_READ)
`ifdef SILIB_RESP_ERRCNT_EN
    ,
    .o_underrun   (w_underrun)
`endif
  );

  assign FD = w_fd_oe ? w_fd : 8'hzz;

endmodule

`default_nettype wire

// File: tb/tb_silib_usb_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_silib_usb_responder
// Brief   : Self-checking bench for silib_usb_responder; pull-ups make a
//           released DATA/FD bus read back as 8'hFF.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_silib_usb_responder;

  localparam logic [15:0] BASE = 16'h4000;
  localparam logic [7:0]  FILL = 8'h00;
  localparam logic [7:0]  ZBUS = 8'hFF;

  logic        clk = 1'b0;
  logic        rst, rd_b, wr_b, fread, fstrobe, host_drv;
  logic [15:0] add;
  logic [7:0]  host_val;
  wire  [7:0]  DATA;
  wire  [7:0]  FD;
`ifdef SILIB_RESP_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  silib_usb_responder_if bus_if ();

  silib_usb_responder dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .RD_B    (rd_b),
    .WR_B    (wr_b),
    .ADD     (add),
    .DATA    (DATA),
    .FREAD   (fread),
    .FSTROBE (fstrobe),
    .FD      (FD),
    .bus     (bus_if)
`ifdef SILIB_RESP_ERRCNT_EN
    ,
    .ERR_CNT (err_cnt)
`endif
  );

  assign DATA = host_drv ? host_val : 8'hzz;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (DATA[gi]);
    pullup (FD[gi]);
  end

  // Peripheral behind the internal bus: 256 bytes, read data one cycle late.
  logic [7:0] bus_mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bus_mem[i] <= 8'(i) ^ 8'h3F;
    end else begin
      if (bus_if.BUS_WR) bus_mem[bus_if.BUS_ADD[7:0]] <= bus_if.BUS_DATA_OUT;
      if (bus_if.BUS_RD) bus_if.BUS_DATA_IN <= bus_mem[bus_if.BUS_ADD[7:0]];
    end
  end

  // FWFT FIFO feeding the fast-read port.
  logic [7:0] f_mem [0:63];
  int f_wp = 0;
  int f_rp = 0;
  int pop_cnt = 0;
  assign bus_if.FIFO_EMPTY = (f_wp == f_rp);
  assign bus_if.FIFO_DATA  = f_mem[f_rp[5:0]];
  always @(posedge clk) begin
    if (bus_if.FIFO_READ) begin
      f_rp    <= f_rp + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Bus pulse monitor.
  int wr_pulses = 0;
  int rd_pulses = 0;
  int overlap = 0;
  logic [15:0] last_wr_add, last_rd_add;
  logic [7:0]  last_wr_data;
  always @(negedge clk) begin
    if (bus_if.BUS_WR) begin
      wr_pulses    <= wr_pulses + 1;
      last_wr_add  <= bus_if.BUS_ADD;
      last_wr_data <= bus_if.BUS_DATA_OUT;
    end
    if (bus_if.BUS_RD) begin
      rd_pulses   <= rd_pulses + 1;
      last_rd_add <= bus_if.BUS_ADD;
    end
    if (bus_if.BUS_WR && bus_if.BUS_RD) overlap <= overlap + 1;
  end

  int n_chk = 0;
  int n_pass = 0;
  int exp_err = 0;
  logic [7:0] ref_mem [0:255];
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3F;
  endtask

  // Transaction-level model: decoded or not, which offset, which byte.
  task automatic ref_apply(input bit wr, input logic [15:0] a, input logic [7:0] d,
                           output int n, output logic [15:0] ba, output logic [7:0] data);
    if (a < BASE) begin
      n = 0; ba = 16'h0000; data = wr ? 8'h00 : ZBUS;
    end else begin
      n = 1; ba = a - BASE;
      if (wr) begin ref_mem[ba[7:0]] = d; data = d; end
      else data = ref_mem[ba[7:0]];
    end
  endtask

  task automatic run_txn(input bit wr, input logic [15:0] a, input logic [7:0] d,
                         output int n, output int stray, output logic [15:0] ba,
                         output logic [7:0] data, output bit rel);
    int w0, r0;
    w0 = wr_pulses; r0 = rd_pulses; data = 8'h00;
    @(negedge clk);
    add = a;
    if (wr) begin
      host_val = d; host_drv = 1'b1; wr_b = 1'b0;
      repeat (3) @(negedge clk);
      wr_b = 1'b1;
      @(negedge clk);
      host_drv = 1'b0;
      #1 rel = (DATA === ZBUS);
    end else begin
      rd_b = 1'b0;
      repeat (3) @(negedge clk);
      data = DATA;
      rd_b = 1'b1;
      #1 rel = (DATA === ZBUS);
    end
    repeat (2) @(negedge clk);
    n     = wr ? wr_pulses - w0 : rd_pulses - r0;
    stray = wr ? rd_pulses - r0 : wr_pulses - w0;
    ba    = wr ? last_wr_add : last_rd_add;
    if (wr) data = last_wr_data;
  endtask

  task automatic check_txn(input string tag, input bit wr, input int exp_n,
                           input logic [15:0] exp_ba, input logic [7:0] exp_d,
                           input int n, input int stray, input logic [15:0] ba,
                           input logic [7:0] data, input bit rel);
    chk({tag, "_pulses"}, 32'(n), 32'(exp_n));
    chk({tag, "_stray"}, 32'(stray), 32'd0);
    if (exp_n != 0) chk({tag, "_addr"}, 32'(ba), 32'(exp_ba));
    if (exp_n != 0 || !wr) chk({tag, "_data"}, 32'(data), 32'(exp_d));
    chk({tag, "_release"}, 32'(rel), 32'd1);
  endtask

  task automatic push_fifo(input logic [7:0] v);
    f_mem[f_wp[5:0]] = v;
    f_wp++;
    exp_q.push_back(v);
  endtask

  task automatic fast_byte(output logic [7:0] b);
    @(negedge clk);
    fstrobe = 1'b1;
    #1 b = FD;
    @(negedge clk);
    fstrobe = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] add;
    logic [7:0]  d;
    int          exp_n;
    logic [15:0] exp_ba;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vt [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stray, p0, exp_p, r0, m, k;
    logic [15:0] ba, e_ba;
    logic [7:0]  data, e_d, b;
    bit rel, wr;
    logic [15:0] a;

    vt[0] = '{1'b1, 16'h4012, 8'hA5, 1, 16'h0012, 8'hA5};
    vt[1] = '{1'b0, 16'h4012, 8'h00, 1, 16'h0012, 8'hA5};
    vt[2] = '{1'b0, 16'h4003, 8'h00, 1, 16'h0003, 8'h3C};
    vt[3] = '{1'b0, 16'h1000, 8'h00, 0, 16'h0000, ZBUS};
    vt[4] = '{1'b1, 16'h3FFF, 8'h77, 0, 16'h0000, 8'h00};
    vt[5] = '{1'b0, 16'h3FFF, 8'h00, 0, 16'h0000, ZBUS};
    vt[6] = '{1'b1, 16'h4000, 8'h01, 1, 16'h0000, 8'h01};
    vt[7] = '{1'b0, 16'h4000, 8'h00, 1, 16'h0000, 8'h01};
    vt[8] = '{1'b1, 16'hFFFF, 8'hC3, 1, 16'hBFFF, 8'hC3};
    vt[9] = '{1'b0, 16'hFFFF, 8'h00, 1, 16'hBFFF, 8'hC3};

    rst = 1'b1; rd_b = 1'b1; wr_b = 1'b1; add = 16'h0000;
    host_drv = 1'b0; host_val = 8'h00; fread = 1'b0; fstrobe = 1'b0;
    ref_reset();
    repeat (3) @(negedge clk);
    chk("rst_bus_rd", 32'(bus_if.BUS_RD), 32'd0);
    chk("rst_bus_wr", 32'(bus_if.BUS_WR), 32'd0);
    chk("rst_bus_add", 32'(bus_if.BUS_ADD), 32'd0);
    chk("rst_bus_dout", 32'(bus_if.BUS_DATA_OUT), 32'd0);
    chk("rst_fifo_read", 32'(bus_if.FIFO_READ), 32'd0);
    chk("rst_data_z", 32'(DATA), 32'(ZBUS));
    chk("rst_fd_z", 32'(FD), 32'(ZBUS));
`ifdef SILIB_RESP_ERRCNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(vt[i].wr, vt[i].add, vt[i].d, n, stray, ba, data, rel);
      check_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].exp_n, vt[i].exp_ba, vt[i].exp_d,
                n, stray, ba, data, rel);
      ref_apply(vt[i].wr, vt[i].add, vt[i].d, n, e_ba, e_d);
    end

    // Strobe released while still in the request phase.
    r0 = rd_pulses;
    @(negedge clk);
    add = 16'h4005; rd_b = 1'b0;
    @(negedge clk);
    rd_b = 1'b1;
    #1 chk("early_rel_z0", 32'(DATA), 32'(ZBUS));
    @(negedge clk);
    #1 chk("early_rel_z1", 32'(DATA), 32'(ZBUS));
    repeat (3) @(negedge clk);
    chk("early_rel_pulses", 32'(rd_pulses - r0), 32'd1);
    chk("early_rel_addr", 32'(last_rd_add), 32'h0005);
    run_txn(1'b0, 16'h4003, 8'h00, n, stray, ba, data, rel);
    ref_apply(1'b0, 16'h4003, 8'h00, k, e_ba, e_d);
    check_txn("after_early", 1'b0, k, e_ba, e_d, n, stray, ba, data, rel);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 16'h3FFF))
                                       : BASE + 16'($urandom_range(0, 31));
      b  = 8'($urandom);
      run_txn(wr, a, b, n, stray, ba, data, rel);
      ref_apply(wr, a, b, k, e_ba, e_d);
      check_txn($sformatf("rnd%0d", i), wr, k, e_ba, e_d, n, stray, ba, data, rel);
    end

    // Four fast reads against three queued bytes.
    push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33);
    @(negedge clk);
    fread = 1'b1;
    #1 chk("fd_head", 32'(FD), 32'h11);
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() != 0) e_d = exp_q.pop_front();
      else begin e_d = FILL; exp_err++; end
      fast_byte(b);
      chk($sformatf("fblk%0d", i), 32'(b), 32'(e_d));
    end
    chk("fblk_pops", 32'(pop_cnt - p0), 32'd3);
    chk("fd_empty_fill", 32'(FD), 32'(FILL));
`ifdef SILIB_RESP_ERRCNT_EN
    chk("err_underrun", 32'(err_cnt), 32'(exp_err));
`endif
    fread = 1'b0;
    #1 chk("fd_released", 32'(FD), 32'(ZBUS));
    push_fifo(8'h44);
    @(negedge clk);
    p0 = pop_cnt;
    fstrobe = 1'b1;
    #1 chk("no_pop_fread_low", 32'(bus_if.FIFO_READ), 32'd0);
    @(negedge clk);
    fstrobe = 1'b0;
    chk("no_pop_count", 32'(pop_cnt - p0), 32'd0);

    fread = 1'b1;
    for (int r = 0; r < 4; r++) begin
      m = $urandom_range(0, 4);
      for (int j = 0; j < m; j++) push_fifo(8'($urandom));
      m = $urandom_range(1, 6);
      p0 = pop_cnt; exp_p = 0;
      for (int j = 0; j < m; j++) begin
        if (exp_q.size() != 0) begin e_d = exp_q.pop_front(); exp_p++; end
        else begin e_d = FILL; exp_err++; end
        fast_byte(b);
        chk($sformatf("frnd%0d_%0d", r, j), 32'(b), 32'(e_d));
      end
      chk($sformatf("frnd%0d_pops", r), 32'(pop_cnt - p0), 32'(exp_p));
    end
    fread = 1'b0;

    // Both strobes falling on the same edge are ignored.
    r0 = rd_pulses; p0 = wr_pulses;
    @(negedge clk);
    add = 16'h4010; host_val = 8'h99; host_drv = 1'b1; rd_b = 1'b0; wr_b = 1'b0;
    exp_err++;
    repeat (3) @(negedge clk);
    rd_b = 1'b1; wr_b = 1'b1;
    @(negedge clk);
    host_drv = 1'b0;
    repeat (2) @(negedge clk);
    chk("both_fall_rd", 32'(rd_pulses - r0), 32'd0);
    chk("both_fall_wr", 32'(wr_pulses - p0), 32'd0);
    chk("both_fall_z", 32'(DATA), 32'(ZBUS));
`ifdef SILIB_RESP_ERRCNT_EN
    chk("err_both_fall", 32'(err_cnt), 32'(exp_err));
`endif

    // Reset while the host is holding a read in its data phase.
    ref_apply(1'b0, 16'h4003, 8'h00, k, e_ba, e_d);
    @(negedge clk);
    add = 16'h4003; rd_b = 1'b0; fread = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold_data", 32'(DATA), 32'(e_d));
    rst = 1'b1;
    #1;
    chk("rst_hold_z", 32'(DATA), 32'(ZBUS));
    chk("rst_hold_fd_z", 32'(FD), 32'(ZBUS));
    chk("rst_hold_rd", 32'(bus_if.BUS_RD), 32'd0);
`ifdef SILIB_RESP_ERRCNT_EN
    chk("rst_hold_err", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0; rd_b = 1'b1; fread = 1'b0;
    ref_reset();
    run_txn(1'b1, 16'h4001, 8'h5A, n, stray, ba, data, rel);
    check_txn("post_rst_wr", 1'b1, 1, 16'h0001, 8'h5A, n, stray, ba, data, rel);

    chk("no_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
